// File: rtl/fp_exe_tracker_pkg.sv
// Shared FP execution-unit interface types plus the tracker's buffered-result entry.
// Stands in for the fp_wire definitions so the tracker slice compiles on its own.
package fp_exe_tracker_pkg;

    typedef struct packed {
        logic       fmadd;
        logic       fmsub;
        logic       fnmsub;
        logic       fnmadd;
        logic       fadd;
        logic       fsub;
        logic       fmul;
        logic       fdiv;
        logic       fsqrt;
        logic       fsgnj;
        logic       fcmp;
        logic       fmax;
        logic       fclass;
        logic       fmv_i2f;
        logic       fmv_f2i;
        logic       fcvt_i2f;
        logic       fcvt_f2i;
        logic [1:0] fcvt_op;
    } fp_operation_type;

    localparam fp_operation_type init_fp_operation = 19'b0;

    typedef struct packed {
        logic [31:0]      data1;
        logic [31:0]      data2;
        logic [31:0]      data3;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        fp_operation_type op;
        logic             enable;
    } fp_exe_in_type;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_exe_out_type;

    // Payload buffered per retired operation; the tag travels alongside it.
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
    } fp_tracker_entry;

    localparam int FP_ENTRY_W = 37;

    function automatic fp_tracker_entry fp_tracker_pack(input logic [31:0] result,
                                                        input logic [4:0]  flags);
        fp_tracker_entry e;
        e.result = result;
        e.flags  = flags;
        return e;
    endfunction

endpackage

// File: rtl/fp_tracker_fifo.sv
// Synchronous FIFO with registered storage, power-of-two depth and an occupancy count.
// Simultaneous push and pop both take effect; pointers wrap naturally.
module fp_tracker_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int          PW     = $clog2(DEPTH);
    localparam logic [PW:0] FULL_C = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE_C  = (PW + 1)'(1);
    localparam logic [PW:0] ZERO_C = (PW + 1)'(0);
    localparam logic [PW-1:0] STEP_C = (PW)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests; a push into a full FIFO only lands alongside a pop.
    always_comb begin
        pop_ok_s  = pop && (count_r != ZERO_C);
        push_ok_s = push && ((count_r != FULL_C) || pop_ok_s);
    end

    // Storage is cleared on reset so an empty FIFO presents an all-zero head.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and count bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= ZERO_C;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + STEP_C;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + STEP_C;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/fp_exe_tracker.sv
// Issue/retire tracker in front of fp_unit: tags requests, matches in-order ready pulses
// to tags and buffers tagged results for a backpressured writeback consumer.
module fp_exe_tracker
    import fp_exe_tracker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_data1,
    input  logic [31:0]      req_data2,
    input  logic [31:0]      req_data3,
    input  logic [1:0]       req_fmt,
    input  logic [2:0]       req_rm,
    input  fp_operation_type req_op,
    output fp_exe_in_type    fp_exe_i,
    input  fp_exe_out_type   fp_exe_o,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_result,
    output logic [4:0]       wb_flags,
    output logic             err_orphan
);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam int          RW      = TAG_W + FP_ENTRY_W;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [CW-1:0]   tag_count_s;
    logic [CW-1:0]   res_count_s;
    logic [CW:0]     occupancy_s;
    logic            accept_s;
    logic            tag_empty_s;
    logic            tag_pop_s;
    logic            wb_pop_s;
    logic [TAG_W-1:0] head_tag_s;
    logic [RW-1:0]   res_push_data_s;
    logic [RW-1:0]   res_head_s;
    fp_tracker_entry head_entry_s;
    logic            err_orphan_r;

    // Credit check uses registered counts only, so req_ready never depends on req_valid or wb_ready.
    always_comb begin
        occupancy_s = {1'b0, tag_count_s} + {1'b0, res_count_s};
        req_ready   = occupancy_s < DEPTH_C;
        accept_s    = req_valid && req_ready;
        tag_empty_s = tag_count_s == {CW{1'b0}};
        tag_pop_s   = fp_exe_o.ready && !tag_empty_s;
        wb_pop_s    = wb_valid && wb_ready;
    end

    // Zero-latency issue: operands pass through, op is masked when nothing is accepted.
    always_comb begin
        fp_exe_i.data1  = req_data1;
        fp_exe_i.data2  = req_data2;
        fp_exe_i.data3  = req_data3;
        fp_exe_i.fmt    = req_fmt;
        fp_exe_i.rm     = req_rm;
        fp_exe_i.enable = accept_s;
        if (accept_s) begin
            fp_exe_i.op = req_op;
        end else begin
            fp_exe_i.op = init_fp_operation;
        end
    end

    // Writeback presents the result FIFO head; fields are meaningful only with wb_valid.
    always_comb begin
        res_push_data_s = {head_tag_s, fp_tracker_pack(fp_exe_o.result, fp_exe_o.flags)};
        head_entry_s    = fp_tracker_entry'(res_head_s[FP_ENTRY_W-1:0]);
        wb_valid        = res_count_s != {CW{1'b0}};
        wb_tag          = res_head_s[RW-1 -: TAG_W];
        wb_result       = head_entry_s.result;
        wb_flags        = head_entry_s.flags;
    end

    // A ready pulse with no outstanding tag latches an error until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_orphan_r <= 1'b0;
        end else if (fp_exe_o.ready && tag_empty_s) begin
            err_orphan_r <= 1'b1;
        end else begin
            err_orphan_r <= err_orphan_r;
        end
    end

    assign err_orphan = err_orphan_r;

    fp_tracker_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept_s),
        .push_data (req_tag),
        .pop       (tag_pop_s),
        .head_data (head_tag_s),
        .count     (tag_count_s)
    );

    fp_tracker_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tag_pop_s),
        .push_data (res_push_data_s),
        .pop       (wb_pop_s),
        .head_data (res_head_s),
        .count     (res_count_s)
    );

endmodule

// File: tb/tb_fp_exe_tracker.sv
// Self-checking bench for fp_exe_tracker: queue-based reference model, a fixed-latency
// fp_unit stand-in, and directed scenarios with hand-computed expectations.
module tb_fp_exe_tracker;
    import fp_exe_tracker_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clock;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      req_data1;
    logic [31:0]      req_data2;
    logic [31:0]      req_data3;
    logic [1:0]       req_fmt;
    logic [2:0]       req_rm;
    fp_operation_type req_op;
    fp_exe_in_type    fp_exe_i;
    fp_exe_out_type   fp_exe_o;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_result;
    logic [4:0]       wb_flags;
    logic             err_orphan;
    logic             inject;

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;
    int pop_cnt  = 0;
    int cyc      = 0;

    fp_exe_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .req_fmt(req_fmt), .req_rm(req_rm), .req_op(req_op),
        .fp_exe_i(fp_exe_i), .fp_exe_o(fp_exe_o),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_result(wb_result), .wb_flags(wb_flags), .err_orphan(err_orphan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference arithmetic for the directed vectors; other inputs get a distinctive mix.
    function automatic logic [36:0] fp_ref(input fp_operation_type op, input logic [31:0] a,
                                           input logic [31:0] b);
        if (op.fadd && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 5'b00000};
        if (op.fadd && a == 32'h3FC00000 && b == 32'h40200000) return {32'h40800000, 5'b00000};
        if (op.fmul && a == 32'h40000000 && b == 32'h40400000) return {32'h40C00000, 5'b00000};
        if (op.fsub && a == 32'h40A00000 && b == 32'h40400000) return {32'h40000000, 5'b00000};
        return {a ^ {b[15:0], b[31:16]}, a[4:0] | 5'b00001};
    endfunction

    // fp_unit stand-in: fixed three-stage pipeline, one in-order ready per enable.
    logic [2:0]  sv_r;
    logic [36:0] sd_r [3];
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sv_r     <= 3'b000;
            sd_r[0]  <= 37'b0;
            sd_r[1]  <= 37'b0;
            sd_r[2]  <= 37'b0;
        end else begin
            sv_r    <= {sv_r[1:0], fp_exe_i.enable};
            sd_r[0] <= fp_ref(fp_exe_i.op, fp_exe_i.data1, fp_exe_i.data2);
            sd_r[1] <= sd_r[0];
            sd_r[2] <= sd_r[1];
        end
    end

    always_comb begin
        fp_exe_o.result = sd_r[2][36:5];
        fp_exe_o.flags  = sd_r[2][4:0];
        fp_exe_o.ready  = sv_r[2] | inject;
    end

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic [4:0]       flg;
    } exp_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        int               cyc;
    } seen_t;

    exp_t  pend_q[$];
    exp_t  avail_q[$];
    seen_t seen_q[$];
    logic  orphan_m = 1'b0;

    // Reference model: issued ops wait in pend_q, retired results in avail_q.
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                pend_q.delete();
                avail_q.delete();
                orphan_m = 1'b0;
            end else begin : upd
                int          occ;
                exp_t        e;
                logic [36:0] rf;
                occ = pend_q.size() + avail_q.size();
                if (avail_q.size() > 0 && wb_ready) void'(avail_q.pop_front());
                if (fp_exe_o.ready) begin
                    if (pend_q.size() > 0) avail_q.push_back(pend_q.pop_front());
                    else orphan_m = 1'b1;
                end
                if (req_valid && occ < DEPTH) begin
                    rf    = fp_ref(req_op, req_data1, req_data2);
                    e.tag = req_tag;
                    e.res = rf[36:5];
                    e.flg = rf[4:0];
                    pend_q.push_back(e);
                end
            end
        end
    end

    // Compare process: every mid-cycle outside reset, DUT against the model.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin : cmp
                int   occ;
                logic acc;
                seen_t s;
                occ = pend_q.size() + avail_q.size();
                acc = req_valid && (occ < DEPTH);
                chk("req_ready", 64'(req_ready), 64'(occ < DEPTH));
                chk("enable", 64'(fp_exe_i.enable), 64'(acc));
                chk("op", 64'(fp_exe_i.op), acc ? 64'(req_op) : 64'(0));
                chk("data12", {fp_exe_i.data1, fp_exe_i.data2}, {req_data1, req_data2});
                chk("data3_fmt_rm", {27'b0, fp_exe_i.data3, fp_exe_i.fmt, fp_exe_i.rm},
                    {27'b0, req_data3, req_fmt, req_rm});
                chk("wb_valid", 64'(wb_valid), 64'(avail_q.size() > 0));
                if (avail_q.size() > 0) begin
                    chk("wb_tag", 64'(wb_tag), 64'(avail_q[0].tag));
                    chk("wb_result", 64'(wb_result), 64'(avail_q[0].res));
                    chk("wb_flags", 64'(wb_flags), 64'(avail_q[0].flg));
                end
                chk("err_orphan", 64'(err_orphan), 64'(orphan_m));
                if (fp_exe_i.enable) en_cnt++;
                if (wb_valid && wb_ready) begin
                    pop_cnt++;
                    s.tag = wb_tag;
                    s.res = wb_result;
                    s.cyc = cyc;
                    seen_q.push_back(s);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [TAG_W-1:0] tag, input fp_operation_type op,
                        input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_valid = 1'b1;
        req_tag   = tag;
        req_op    = op;
        req_data1 = a;
        req_data2 = b;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) chk("send_timeout", 64'(0), 64'(1));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        while (!wb_valid && n < 50) begin
            tick();
            n++;
        end
        if (!wb_valid) chk("wb_timeout", 64'(0), 64'(1));
    endtask

    fp_operation_type op_add, op_sub, op_mul;

    initial begin : stim
        int n;
        int en0;
        int p0;
        int seen_valid;
        op_add = init_fp_operation; op_add.fadd = 1'b1;
        op_sub = init_fp_operation; op_sub.fsub = 1'b1;
        op_mul = init_fp_operation; op_mul.fmul = 1'b1;
        reset = 1'b1; req_valid = 1'b0; req_tag = '0; req_data1 = 32'h0; req_data2 = 32'h0;
        req_data3 = 32'h0; req_fmt = 2'b00; req_rm = 3'b000; req_op = init_fp_operation;
        wb_ready = 1'b0; inject = 1'b0;

        #12;
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_wb", {26'b0, wb_valid, wb_tag, wb_result}, 64'(0));
        chk("rst_flags_err_en", 64'({wb_flags, err_orphan, fp_exe_i.enable}), 64'(0));
        tick();
        reset = 1'b0;
        tick();

        // Single add: result visible three edges after the accept edge.
        wb_ready = 1'b1;
        req_data3 = 32'hDEADBEEF; req_fmt = 2'b01; req_rm = 3'b010;
        send(5'd5, op_add, 32'h3F800000, 32'h40000000);
        req_data3 = 32'h0; req_fmt = 2'b00; req_rm = 3'b000;
        wait_wb(n);
        chk("single_latency", 64'(n), 64'(3));
        chk("single_tag", 64'(wb_tag), 64'(5));
        chk("single_result", 64'(wb_result), 64'(32'h40400000));
        chk("single_flags", 64'(wb_flags), 64'(0));
        repeat (4) tick();

        // Ordering: three back-to-back issues come back in order with no gaps.
        seen_q.delete();
        send(5'd1, op_mul, 32'h40000000, 32'h40400000);
        send(5'd2, op_add, 32'h3FC00000, 32'h40200000);
        send(5'd3, op_sub, 32'h40A00000, 32'h40400000);
        repeat (10) tick();
        chk("order_count", 64'(seen_q.size()), 64'(3));
        if (seen_q.size() == 3) begin
            chk("order_tags", 64'({seen_q[0].tag, seen_q[1].tag, seen_q[2].tag}),
                64'({5'd1, 5'd2, 5'd3}));
            chk("order_res0", 64'(seen_q[0].res), 64'(32'h40C00000));
            chk("order_res1", 64'(seen_q[1].res), 64'(32'h40800000));
            chk("order_res2", 64'(seen_q[2].res), 64'(32'h40000000));
            chk("order_gapless", 64'(seen_q[2].cyc - seen_q[0].cyc), 64'(2));
        end

        // Full: with writeback stalled, exactly DEPTH accepts.
        wb_ready = 1'b0;
        en0 = en_cnt;
        p0  = pop_cnt;
        req_op = op_add;
        req_data2 = 32'h00020003;
        for (int i = 0; i < 12; i++) begin
            req_valid = 1'b1;
            req_tag   = TAG_W'(10 + i);
            req_data1 = 32'h1000 + 32'(i);
            tick();
        end
        chk("full_accepts", 64'(en_cnt - en0), 64'(4));
        chk("full_ready", 64'(req_ready), 64'(0));

        // Pop and request in the same cycle: credit frees only on the next cycle.
        wb_ready = 1'b1;
        @(negedge clock); #1;
        chk("simul_ready_low", 64'(req_ready), 64'(0));
        chk("simul_enable_low", 64'(fp_exe_i.enable), 64'(0));
        tick();
        wb_ready = 1'b0;
        @(negedge clock); #1;
        chk("simul_ready_next", 64'(req_ready), 64'(1));
        chk("simul_enable_next", 64'(fp_exe_i.enable), 64'(1));
        tick();
        chk("simul_refull", 64'(req_ready), 64'(0));

        // Drain with requests still arriving: one accept per pop, nothing lost.
        wb_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_tag   = TAG_W'(i);
            req_data1 = 32'h5000 + 32'(i * 7);
            tick();
        end
        req_valid = 1'b0;
        repeat (20) tick();
        chk("drain_balance", 64'(pop_cnt - p0), 64'(en_cnt - en0));
        chk("drain_empty", 64'(wb_valid), 64'(0));

        // Orphan ready pulse with nothing outstanding.
        repeat (3) tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("orphan_set", 64'(err_orphan), 64'(1));
        chk("orphan_no_wb", 64'(wb_valid), 64'(0));
        repeat (5) tick();
        chk("orphan_hold", 64'(err_orphan), 64'(1));

        // Reset with three operations outstanding.
        wb_ready = 1'b0;
        send(5'd20, op_add, 32'h11111111, 32'h22222222);
        send(5'd21, op_add, 32'h33333333, 32'h44444444);
        send(5'd22, op_add, 32'h55555555, 32'h66666666);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'(1));
        chk("mid_rst_wb", {26'b0, wb_valid, wb_tag, wb_result}, 64'(0));
        chk("mid_rst_flags_err_en", 64'({wb_flags, err_orphan, fp_exe_i.enable}), 64'(0));
        tick();
        reset = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (wb_valid) seen_valid++;
            tick();
        end
        chk("post_rst_no_wb", 64'(seen_valid), 64'(0));
        chk("post_rst_ready", 64'(req_ready), 64'(1));
        wb_ready = 1'b1;
        send(5'd9, op_add, 32'h3F800000, 32'h40000000);
        wait_wb(n);
        chk("post_rst_tag", 64'(wb_tag), 64'(9));
        chk("post_rst_result", 64'(wb_result), 64'(32'h40400000));
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_exe_tracker.md
# fp_exe_tracker

Synthesizable issue/retire tracker between a request source (core or bench sequencer) and `fp_unit`. It accepts tagged FP requests with valid/ready, drives `fp_exe_i`, matches each `fp_exe_o.ready` pulse to its tag, and presents tagged results to a writeback consumer with valid/ready backpressure. It is the result-collecting counterpart of the request driver: the consumer of `fp_unit` outputs, with credit-based flow control so no result is ever dropped.

## Interface
Parameters:
- DEPTH, 4, maximum operations outstanding (in flight in `fp_unit` plus buffered results); power of two, 2..16
- TAG_W, 5, width of request/result tag

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_tag  in  TAG_W  tag returned with the result
- req_data1/req_data2/req_data3  in  32  operands
- req_fmt  in  2  format
- req_rm  in  3  rounding mode
- req_op  in  fp_operation_type  operation one-hot
- fp_exe_i  out  fp_exe_in_type  to `fp_unit`
- fp_exe_o  in  fp_exe_out_type  from `fp_unit` (result, flags, ready)
- wb_valid  out  1  result present
- wb_ready  in  1  consumer takes result
- wb_tag  out  TAG_W  tag of presented result
- wb_result  out  32  result word
- wb_flags  out  5  NV/DZ/OF/UF/NX
- err_orphan  out  1  sticky: `fp_exe_o.ready` arrived with no outstanding tag

## Operation
- Accept = req_valid & req_ready. On accept, same cycle: `fp_exe_i.enable`=1, data/fmt/rm/op passed through combinationally; tag pushed into tag FIFO.
- No accept: `fp_exe_i.enable`=0, `op`=init_fp_operation, data/fmt/rm still pass through.
- `fp_unit` retires in issue order, exactly one ready pulse per enable.
- On `fp_exe_o.ready`: pop tag FIFO head; push {tag, result, flags} into result FIFO.
- Ready with tag FIFO empty: no push, err_orphan set, holds until reset.
- wb_* driven from result FIFO head; pop on wb_valid & wb_ready.
- Credit: occupancy = tag FIFO count + result FIFO count (0..DEPTH). req_ready = (occupancy < DEPTH). Guarantees result FIFO cannot overflow.
- Occupancy next = occ + accept − wb_pop; simultaneous accept and pop leave it unchanged; retire moves an entry between FIFOs without changing it.
- Same-cycle push and pop on either FIFO both take effect; pointers wrap mod DEPTH.
- wb_valid low: wb_tag/wb_result/wb_flags are don't-care (implementation presents head entry).

## Timing
- Issue latency 0: accept cycle is the `fp_unit` enable cycle.
- Retire: result FIFO written at the rising edge ending the ready cycle; wb_valid rises the next cycle (1-cycle registered, no bypass).
- req_ready combinational from registered counts only; no path from req_valid or wb_ready.
- Reset values: req_ready=1, wb_valid=0, wb_tag/result/flags=0, err_orphan=0, `fp_exe_i.enable`=0, both FIFOs empty.
- Reset mid-operation discards all outstanding tags and buffered results; `fp_unit` shares the same reset so no stale ready pulses follow.
- Throughput: one accept and one writeback per cycle sustained while wb_ready=1 and DEPTH covers `fp_unit` latency.

## Structure
- fp_wire package: reuse fp_exe_in_type, fp_exe_out_type, fp_operation_type, init_fp_operation; add a fp_tracker_entry struct (tag, result, flags).
- One sub-module, `fp_tracker_fifo` (parameterized width/depth, push/pop/count, registered storage), instantiated twice: tag FIFO (TAG_W) and result FIFO (TAG_W+37).
- Top holds occupancy logic, enable/op muxing, err_orphan register.

## Test plan
- Single op: f32_add 0x3F800000 + 0x40000000, rm=0, tag 5, wb_ready=1 -> wb_valid one cycle after ready, wb_tag=5, wb_result=0x40400000, wb_flags=0.
- Ordering: tags 1,2,3 issued back-to-back as fmul/fadd/fsub -> wb_tag sequence 1,2,3 with matching results, no gaps beyond `fp_unit` latency.
- Full: DEPTH=4, wb_ready=0, req_valid held -> exactly 4 accepts, req_ready=0 after 4th, `fp_exe_i.enable` never asserted for 5th; raise wb_ready -> one accept per pop, no loss.
- Simultaneous: at occupancy 4, wb pop and req_valid same cycle -> req_ready stays 0 that cycle (registered count), accept next cycle; occupancy never exceeds 4.
- Orphan: force `fp_exe_o.ready`=1 with nothing outstanding -> err_orphan=1, wb_valid stays 0, err_orphan holds until reset.
- Reset mid-run: assert reset with 3 outstanding -> all outputs at reset values immediately (async), after release req_ready=1, no wb_valid until new requests.
